// File: rtl/calc_cmd_seq.sv
`default_nettype none
// ============================================================================
// Module      : calc_cmd_seq
// Description : Buffers calculator key codes in a small FIFO and plays them
//               into calc_top's cmd input with fixed hold/gap timing, gated
//               by calc_top's busy status, with error/timeout flush.
// Revision    : 1.0 - initial release
// ============================================================================
module calc_cmd_seq #(
    parameter int         DEPTH       = 4,
    parameter int         HOLD_CYCLES = 5,
    parameter int         GAP_CYCLES  = 2,
    parameter int         TIMEOUT     = 255,
    parameter logic [3:0] IDLE_CMD    = 4'b1111
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [3:0]               cmd_in,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [1:0]               calc_status,
    output logic [3:0]               cmd_out,
    output logic                     seq_busy,
    output logic                     err,
    output logic                     tmo,
    input  logic                     err_clr,
    output logic [$clog2(DEPTH):0]   fill
);

    localparam int c_aw = $clog2(DEPTH);
    localparam int c_cw = $clog2(((HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES) + 1);
    localparam int c_tw = $clog2(TIMEOUT + 1);
    localparam logic [c_aw:0]   c_depth    = (c_aw + 1)'(DEPTH);
    localparam logic [c_cw-1:0] c_hold_ld  = c_cw'(HOLD_CYCLES - 1);
    localparam logic [c_cw-1:0] c_gap_ld   = c_cw'(GAP_CYCLES - 1);
    localparam logic [c_tw-1:0] c_tmo_last = c_tw'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_DRIVE = 3'd1,
        S_GAP   = 3'd2,
        S_WAIT  = 3'd3,
        S_ERR   = 3'd4
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [3:0]        r_mem [DEPTH];
    logic [c_aw-1:0]   r_wr_ptr;
    logic [c_aw-1:0]   r_rd_ptr;
    logic [c_aw:0]     r_fill;
    logic [3:0]        r_cmd;
    logic [c_cw-1:0]   r_cnt;
    logic [c_tw-1:0]   r_tcnt;
    logic              r_err;
    logic              r_tmo;

    logic [3:0]        w_cmd_nxt;
    logic [c_cw-1:0]   w_cnt_nxt;
    logic [c_tw-1:0]   w_tcnt_nxt;
    logic              w_push;
    logic              w_pop;
    logic              w_flush;
    logic              w_err_set;
    logic              w_tmo_set;
    logic              w_clr;
    logic              w_has_cmd;

    assign cmd_ready = (r_fill < c_depth) && (r_state != S_ERR);
    assign w_push    = cmd_valid && cmd_ready;
    assign w_has_cmd = (r_fill != '0);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cmd_nxt   = r_cmd;
        w_cnt_nxt   = r_cnt;
        w_tcnt_nxt  = r_tcnt;
        w_pop       = 1'b0;
        w_flush     = 1'b0;
        w_err_set   = 1'b0;
        w_tmo_set   = 1'b0;
        w_clr       = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_cmd_nxt = IDLE_CMD;
                if (w_has_cmd && (calc_status == 2'b00)) begin
                    w_pop       = 1'b1;
                    w_cmd_nxt   = r_mem[r_rd_ptr];
                    w_cnt_nxt   = c_hold_ld;
                    w_state_nxt = S_DRIVE;
                end
            end
            S_DRIVE: begin
                if (r_cnt == '0) begin
                    w_cmd_nxt   = IDLE_CMD;
                    w_cnt_nxt   = c_gap_ld;
                    w_state_nxt = S_GAP;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            S_GAP: begin
                if (r_cnt == '0) begin
                    w_tcnt_nxt  = '0;
                    w_state_nxt = S_WAIT;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            S_WAIT: begin
                if (calc_status[1]) begin
                    w_err_set   = 1'b1;
                    w_flush     = 1'b1;
                    w_state_nxt = S_ERR;
                end else if (calc_status == 2'b00) begin
                    // The ready decision here doubles as IDLE's issue slot, so
                    // back-to-back codes are HOLD+GAP+1 cycles apart.
                    if (w_has_cmd) begin
                        w_pop       = 1'b1;
                        w_cmd_nxt   = r_mem[r_rd_ptr];
                        w_cnt_nxt   = c_hold_ld;
                        w_state_nxt = S_DRIVE;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end else if (r_tcnt == c_tmo_last) begin
                    w_tmo_set   = 1'b1;
                    w_flush     = 1'b1;
                    w_state_nxt = S_ERR;
                end else begin
                    w_tcnt_nxt = r_tcnt + 1'b1;
                end
            end
            S_ERR: begin
                w_cmd_nxt = IDLE_CMD;
                if (err_clr) begin
                    w_clr       = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_cmd_nxt   = IDLE_CMD;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_cmd    <= IDLE_CMD;
            r_cnt    <= '0;
            r_tcnt   <= '0;
            r_err    <= 1'b0;
            r_tmo    <= 1'b0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_fill   <= '0;
        end else begin
            r_cmd  <= w_cmd_nxt;
            r_cnt  <= w_cnt_nxt;
            r_tcnt <= w_tcnt_nxt;
            if (w_clr) begin
                r_err <= 1'b0;
                r_tmo <= 1'b0;
            end else begin
                if (w_err_set) r_err <= 1'b1;
                if (w_tmo_set) r_tmo <= 1'b1;
            end
            // Entering ERR discards everything, including a same-cycle push.
            if (w_flush) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_fill   <= '0;
            end else begin
                if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
                if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
                case ({w_push, w_pop})
                    2'b10:   r_fill <= r_fill + 1'b1;
                    2'b01:   r_fill <= r_fill - 1'b1;
                    default: r_fill <= r_fill;
                endcase
            end
        end
    end

    always_ff @(posedge clock) begin
        if (w_push && !w_flush) begin
            r_mem[r_wr_ptr] <= cmd_in;
        end
    end

    assign cmd_out  = r_cmd;
    assign err      = r_err;
    assign tmo      = r_tmo;
    assign fill     = r_fill;
    assign seq_busy = (r_state != S_IDLE) || w_has_cmd;

endmodule
`default_nettype wire
